pvt_measure_sequencer: RTL and testbench
========================================

# pvt_measure_sequencer

Single-clock sequencer that runs one complete PVT measurement scan over the monitor suite. It gates the two divided ring-oscillator outputs into 16-bit frequency counts, fires the start strobe shared by the three clk-q/setup measurement units, then captures their counts together with the skew code. Results are streamed out one channel per transfer over a valid/ready port. It sits between the monitor instances and the readback/host logic in the top level.

## Interface
- `GATE_CYCLES`, default 1024: length of the frequency-count window in clk cycles (≥4).
- `SETTLE_CYCLES`, default 16: wait between `meas_start` and result capture (≥1).
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `run`  in  1  level: scan continuously while high.
- `single`  in  1  one-cycle request: perform exactly one scan.
- `osc_in`  in  2  divided ring-osc clocks; [0] = inverter ring, [1] = NAND2 ring; asynchronous to clk.
- `meas_cnt_dff`, `meas_cnt_dice`, `meas_cnt_leap`  in  8 each  counts from the DFF, DICE and LEAP-DICE measurement units.
- `skew_code`  in  7  code from the skew monitor.
- `osc_ena`  out  1  ring-oscillator enable.
- `meas_start`  out  1  start strobe to the measurement units.
- `busy`  out  1  high in every state except IDLE.
- `res_valid`  out  1; `res_ready`  in  1  result handshake.
- `res_ch`  out  3  channel code: 0 inv, 1 nand2, 2 dff, 3 dice, 4 leap, 5 skew.
- `res_data`  out  16  result; 8-bit and 7-bit sources are zero-extended.

## Operation
- States: IDLE → WARMUP → GATE → TRIG → SETTLE → CAPTURE → EMIT → (WARMUP | IDLE).
- IDLE: all outputs 0. `single` or `run` high → WARMUP. `single` while busy is ignored.
- WARMUP: `osc_ena`=1 for `WARMUP_CYCLES`=8 cycles. Both edge counters are cleared.
- GATE: `osc_ena`=1 for `GATE_CYCLES` cycles.
  - Each `osc_in` bit passes through a 2-flop synchronizer and a rising-edge detector.
  - Each detected edge increments that channel's counter.
  - Counters saturate at 0xFFFF and do not wrap.
- TRIG: `osc_ena`=0 and `meas_start`=1 for exactly one cycle.
- SETTLE: `SETTLE_CYCLES` cycles; `meas_start`=0.
- CAPTURE: one cycle. `meas_cnt_*` and `skew_code` are latched into holding registers.
- EMIT: channels are presented in order 0..5.
  - `res_valid`=1 throughout.
  - `res_ch`/`res_data` are held stable while `res_valid && !res_ready`.
  - A transfer on ch 5 ends the scan. Then: `run` high → WARMUP; otherwise → IDLE.
- If `run` falls mid-scan, the current scan completes, then the block goes to IDLE.
- `rst_n` low at any time: state returns to IDLE and all counters/holding registers clear.

## Timing
- `single` sampled high at edge N → WARMUP and `osc_ena`=1 from N+1.
- GATE occupies edges N+9 … N+8+GATE_CYCLES.
- Synchronizer latency is 2 cycles. Edges are counted when their synchronized detect falls inside GATE.
- `meas_start` is high for the single cycle after GATE.
- First `res_valid` appears SETTLE_CYCLES+2 cycles after the `meas_start` cycle.
- With `res_ready` held high, EMIT takes 6 cycles (back-to-back, one transfer per cycle).
- With `run` held high, the next scan's WARMUP follows the final transfer with no idle cycle.
- Counted frequency: f_osc_div = count · f_clk / GATE_CYCLES, ±1 count.

## Configuration
- `PVT_SEQ_SKEW_EN` defined: channel 5 (skew) is captured and emitted; the scan emits 6 results.
- Not defined: `skew_code` is ignored (no holding register) and EMIT ends after ch 4 (5 results). All other timing is unchanged.

## Structure
- Package `pvt_seq_pkg` holds:
  - state enum;
  - channel code localparams;
  - `WARMUP_CYCLES`=8;
  - `CNT_W`=16.
- Sub-module `pvt_edge_counter`, instantiated twice: 2-flop synchronizer, rising-edge detect, clear, enable and saturating `CNT_W` counter.

## Test plan
- Reset check (GATE_CYCLES=64, SETTLE_CYCLES=4): hold `rst_n` low → all outputs 0, `busy`=0.
- Frequency count: `osc_in[0]` period 8 clk, `osc_in[1]` period 16 clk, pulse `single`, `res_ready`=1.
  - Expect transfers ch0=8±1, ch1=4±1.
  - Expect `meas_start` exactly 1 cycle at N+73.
- Capture and zero-extend: meas_cnt_dff=0x5A, dice=0xA5, leap=0xFF, skew_code=0x7F.
  - Expect ch2=0x005A, ch3=0x00A5, ch4=0x00FF, ch5=0x007F (ch5 only with `PVT_SEQ_SKEW_EN`; else 5 transfers).
- Backpressure: `res_ready` low 10 cycles during ch1 → `res_valid`, `res_ch`=1 and `res_data` held unchanged; no channel skipped.
- Saturation: GATE_CYCLES=200000, `osc_in[0]` toggled at max detectable rate → ch0=0xFFFF.
- Continuous and reset mid-scan:
  - `run`=1 → second WARMUP immediately after the final transfer.
  - Drop `run` in GATE → the scan completes, then IDLE.
  - Assert `rst_n` low in SETTLE → IDLE next cycle, no `res_valid`.

Source files
------------

// File: rtl/pvt_seq_pkg.sv
// Shared types and constants for the PVT measurement sequencer.
// PVT_SEQ_SKEW_EN selects whether the skew channel is part of the scan.
package pvt_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_GATE,
    S_TRIG,
    S_SETTLE,
    S_CAPTURE,
    S_EMIT
  } state_e;

  localparam logic [2:0] CH_INV   = 3'd0;
  localparam logic [2:0] CH_NAND2 = 3'd1;
  localparam logic [2:0] CH_DFF   = 3'd2;
  localparam logic [2:0] CH_DICE  = 3'd3;
  localparam logic [2:0] CH_LEAP  = 3'd4;
  localparam logic [2:0] CH_SKEW  = 3'd5;

`ifdef PVT_SEQ_SKEW_EN
  localparam logic [2:0] CH_LAST = CH_SKEW;
`else
  localparam logic [2:0] CH_LAST = CH_LEAP;
`endif

  localparam int unsigned WARMUP_CYCLES = 8;
  localparam int unsigned CNT_W         = 16;

endpackage

// File: rtl/pvt_edge_counter.sv
// Synchronised rising-edge counter for one divided ring-oscillator output:
// 2-flop synchroniser, edge detect, clear, enable, saturating count.
module pvt_edge_counter
  import pvt_seq_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         osc_in,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // [1:0] synchroniser stages, [2] previous synchronised level
  logic [2:0]   sync_q, sync_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         rise;

  always_comb begin
    sync_d = {sync_q[1:0], osc_in};
    rise   = sync_q[1] & ~sync_q[2];
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && rise && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pvt_measure_sequencer.sv
// One-shot / continuous PVT scan: gate ring-osc counts, strobe the measurement
// units, capture their results and stream them out. Skew channel under PVT_SEQ_SKEW_EN.
module pvt_measure_sequencer
  import pvt_seq_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = 1024,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        single,
  input  logic [1:0]  osc_in,
  input  logic [7:0]  meas_cnt_dff,
  input  logic [7:0]  meas_cnt_dice,
  input  logic [7:0]  meas_cnt_leap,
  input  logic [6:0]  skew_code,
  output logic        osc_ena,
  output logic        meas_start,
  output logic        busy,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [2:0]  res_ch,
  output logic [15:0] res_data
);

  localparam int unsigned TMAX0 = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMAX  = (TMAX0 > WARMUP_CYCLES) ? TMAX0 : WARMUP_CYCLES;
  localparam int unsigned TW    = $clog2(TMAX);

  localparam logic [TW-1:0] WARM_LD   = TW'(WARMUP_CYCLES - 1);
  localparam logic [TW-1:0] GATE_LD   = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [2:0]      ch_q, ch_d;
  logic [7:0]      dff_q, dff_d, dice_q, dice_d, leap_q, leap_d;
  logic            cnt_clr, cnt_en;
  logic [CNT_W-1:0] cnt_inv, cnt_nand;

`ifdef PVT_SEQ_SKEW_EN
  logic [6:0]      skew_q, skew_d;
`else
  logic            unused_skew;
  assign unused_skew = ^skew_code;
`endif

  pvt_edge_counter #(.W(CNT_W)) u_cnt_inv (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_in[0]), .clr(cnt_clr), .en(cnt_en), .cnt(cnt_inv)
  );

  pvt_edge_counter #(.W(CNT_W)) u_cnt_nand (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_in[1]), .clr(cnt_clr), .en(cnt_en), .cnt(cnt_nand)
  );

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    ch_d       = ch_q;
    dff_d      = dff_q;
    dice_d     = dice_q;
    leap_d     = leap_q;
`ifdef PVT_SEQ_SKEW_EN
    skew_d     = skew_q;
`endif
    osc_ena    = 1'b0;
    meas_start = 1'b0;
    res_valid  = 1'b0;
    res_ch     = '0;
    res_data   = '0;
    busy       = (state_q != S_IDLE);
    cnt_clr    = (state_q == S_WARMUP);
    cnt_en     = (state_q == S_GATE);

    case (state_q)
      S_IDLE: begin
        if (single || run) begin
          state_d = S_WARMUP;
          tmr_d   = WARM_LD;
        end
      end
      S_WARMUP: begin
        osc_ena = 1'b1;
        if (tmr_q == '0) begin
          state_d = S_GATE;
          tmr_d   = GATE_LD;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_GATE: begin
        osc_ena = 1'b1;
        if (tmr_q == '0) begin
          state_d = S_TRIG;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_TRIG: begin
        meas_start = 1'b1;
        state_d    = S_SETTLE;
        tmr_d      = SETTLE_LD;
      end
      S_SETTLE: begin
        if (tmr_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_CAPTURE: begin
        dff_d   = meas_cnt_dff;
        dice_d  = meas_cnt_dice;
        leap_d  = meas_cnt_leap;
`ifdef PVT_SEQ_SKEW_EN
        skew_d  = skew_code;
`endif
        ch_d    = CH_INV;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        res_valid = 1'b1;
        res_ch    = ch_q;
        case (ch_q)
          CH_INV:   res_data = cnt_inv;
          CH_NAND2: res_data = cnt_nand;
          CH_DFF:   res_data = 16'(dff_q);
          CH_DICE:  res_data = 16'(dice_q);
          CH_LEAP:  res_data = 16'(leap_q);
`ifdef PVT_SEQ_SKEW_EN
          CH_SKEW:  res_data = 16'(skew_q);
`endif
          default:  res_data = '0;
        endcase
        if (res_ready) begin
          if (ch_q == CH_LAST) begin
            ch_d = CH_INV;
            // run is sampled only here, so a scan in flight always finishes
            if (run) begin
              state_d = S_WARMUP;
              tmr_d   = WARM_LD;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            ch_d = ch_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      ch_q    <= '0;
      dff_q   <= '0;
      dice_q  <= '0;
      leap_q  <= '0;
`ifdef PVT_SEQ_SKEW_EN
      skew_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ch_q    <= ch_d;
      dff_q   <= dff_d;
      dice_q  <= dice_d;
      leap_q  <= leap_d;
`ifdef PVT_SEQ_SKEW_EN
      skew_q  <= skew_d;
`endif
    end
  end

endmodule

// File: tb/tb_pvt_measure_sequencer.sv
// Self-checking bench for pvt_measure_sequencer: scan-timeline model plus
// directed scans (frequency, capture, backpressure, run, reset, saturation).
module tb_pvt_measure_sequencer;

  localparam int G  = 64;
  localparam int S  = 4;
  localparam int E0 = 10 + G + S;
`ifdef PVT_SEQ_SKEW_EN
  localparam int NCH = 6;
`else
  localparam int NCH = 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run = 1'b0;
  logic        single = 1'b0;
  logic        osc0 = 1'b0;
  logic        osc1 = 1'b0;
  logic [1:0]  osc_in;
  logic [7:0]  meas_cnt_dff = '0;
  logic [7:0]  meas_cnt_dice = '0;
  logic [7:0]  meas_cnt_leap = '0;
  logic [6:0]  skew_code = '0;
  logic        osc_ena, meas_start, busy, res_valid;
  logic        res_ready = 1'b1;
  logic [2:0]  res_ch;
  logic [15:0] res_data;

  logic        sat_in = 1'b0;
  logic        sat_clr = 1'b0;
  logic        sat_en = 1'b0;
  logic [3:0]  sat_cnt;

  assign osc_in = {osc1, osc0};

  pvt_measure_sequencer #(.GATE_CYCLES(G), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .single(single), .osc_in(osc_in),
    .meas_cnt_dff(meas_cnt_dff), .meas_cnt_dice(meas_cnt_dice), .meas_cnt_leap(meas_cnt_leap),
    .skew_code(skew_code), .osc_ena(osc_ena), .meas_start(meas_start), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch), .res_data(res_data)
  );

  pvt_edge_counter #(.W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .osc_in(sat_in), .clr(sat_clr), .en(sat_en), .cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ring-osc periods in clk cycles; 0 stops the oscillator
  int p0 = 8;
  int p1 = 16;
  initial begin
    #3;
    forever begin
      if (p0 == 0) #10;
      else #(p0 * 5) osc0 = ~osc0;
    end
  end
  initial begin
    #3;
    forever begin
      if (p1 == 0) #10;
      else #(p1 * 5) osc1 = ~osc1;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input bit ok, input int act, input int exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
  endtask

  typedef struct { int ch; int exp; int tol; } exp_t;
  typedef struct { int ch; int data; int cyc; } xfer_t;

  exp_t  mq[$];
  xfer_t xlog[$];
  int    mslog[$];
  int    vrise[$];

  bit m_act = 1'b0;
  int m_t = 0;
  bit e_val, e_osc, e_ms, prev_valid = 1'b0;
  int d;

  function automatic int freq_exp(input int p);
    return (p == 0) ? 0 : G / p;
  endfunction

  task automatic build_expect();
    mq.delete();
    mq.push_back('{0, freq_exp(p0), (p0 == 0) ? 0 : 1});
    mq.push_back('{1, freq_exp(p1), (p1 == 0) ? 0 : 1});
    mq.push_back('{2, int'(meas_cnt_dff), 0});
    mq.push_back('{3, int'(meas_cnt_dice), 0});
    mq.push_back('{4, int'(meas_cnt_leap), 0});
    if (NCH == 6) mq.push_back('{5, int'(skew_code), 0});
  endtask

  // Scan-timeline model: m_t counts cycles since the scan's first WARMUP cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_act = 1'b0;
      mq.delete();
    end
    e_val = m_act && (m_t >= E0);
    e_osc = m_act && (m_t < 8 + G);
    e_ms  = m_act && (m_t == 8 + G);
    chk("busy", busy == m_act, int'(busy), int'(m_act));
    chk("osc_ena", osc_ena == e_osc, int'(osc_ena), int'(e_osc));
    chk("meas_start", meas_start == e_ms, int'(meas_start), int'(e_ms));
    chk("res_valid", res_valid == e_val, int'(res_valid), int'(e_val));
    if (!m_act) begin
      chk("idle_res_ch", res_ch == 3'd0, int'(res_ch), 0);
      chk("idle_res_data", res_data == 16'd0, int'(res_data), 0);
    end

    if (res_valid && res_ready) xlog.push_back('{int'(res_ch), int'(res_data), cyc});
    if (meas_start) mslog.push_back(cyc + 1);
    if (res_valid && !prev_valid) vrise.push_back(cyc);
    prev_valid = res_valid;

    if (e_val && mq.size() > 0) begin
      d = int'(res_data) - mq[0].exp;
      chk("res_ch", int'(res_ch) == mq[0].ch, int'(res_ch), mq[0].ch);
      chk("res_data", (d <= mq[0].tol) && (d >= -mq[0].tol), int'(res_data), mq[0].exp);
      if (res_ready) begin
        mq.delete(0);
        if (mq.size() == 0) begin
          if (run) m_t = 0;
          else m_act = 1'b0;
        end
      end
    end else if (m_act) begin
      if (m_t == E0 - 1) build_expect();
      m_t++;
    end else if (rst_n && (single || run)) begin
      m_act = 1'b1;
      m_t   = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_single(output int n);
    tick();
    single = 1'b1;
    n = cyc + 1;
    tick();
    single = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    @(negedge clk);
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", !busy, int'(busy), 0);
  endtask

  task automatic wait_xfers(input int k, input int maxc);
    int n = 0;
    @(negedge clk);
    while (xlog.size() < k && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("wait_xfers", xlog.size() >= k, xlog.size(), k);
  endtask

  task automatic wait_ch0_valid(input int maxc);
    int n = 0;
    @(negedge clk);
    while (!(res_valid && res_ch == 3'd0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ch0", res_valid && res_ch == 3'd0, int'(res_ch), 0);
  endtask

  task automatic wait_ms(input int maxc);
    int n = 0;
    @(negedge clk);
    while (mslog.size() == 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("wait_meas_start", mslog.size() > 0, mslog.size(), 1);
  endtask

  task automatic clear_logs();
    xlog.delete();
    mslog.delete();
    vrise.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int n0, d1;

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy == 1'b0, int'(busy), 0);
    chk("rst_osc_ena", osc_ena == 1'b0, int'(osc_ena), 0);
    chk("rst_meas_start", meas_start == 1'b0, int'(meas_start), 0);
    chk("rst_res_valid", res_valid == 1'b0, int'(res_valid), 0);
    chk("rst_res_data", res_data == 16'd0, int'(res_data), 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // scan 1: frequency count, capture and zero-extension, timing
    meas_cnt_dff = 8'h5A; meas_cnt_dice = 8'hA5; meas_cnt_leap = 8'hFF; skew_code = 7'h7F;
    res_ready = 1'b1;
    clear_logs();
    pulse_single(n0);
    wait_idle(300);
    chk("s1_xfer_count", xlog.size() == NCH, xlog.size(), NCH);
    chk("s1_ms_count", mslog.size() == 1, mslog.size(), 1);
    if (mslog.size() >= 1) chk("s1_ms_cycle", mslog[0] == n0 + 73, mslog[0] - n0, 73);
    if (vrise.size() >= 1) chk("s1_first_valid", vrise[0] == n0 + 78, vrise[0] - n0, 78);
    if (xlog.size() == NCH) begin
      chk("s1_ch0_freq", xlog[0].ch == 0 && xlog[0].data >= 7 && xlog[0].data <= 9, xlog[0].data, 8);
      chk("s1_ch1_freq", xlog[1].ch == 1 && xlog[1].data >= 3 && xlog[1].data <= 5, xlog[1].data, 4);
      chk("s1_ch2_dff", xlog[2].data == 32'h005A, xlog[2].data, 32'h005A);
      chk("s1_ch3_dice", xlog[3].data == 32'h00A5, xlog[3].data, 32'h00A5);
      chk("s1_ch4_leap", xlog[4].data == 32'h00FF, xlog[4].data, 32'h00FF);
`ifdef PVT_SEQ_SKEW_EN
      chk("s1_ch5_skew", xlog[5].ch == 5 && xlog[5].data == 32'h007F, xlog[5].data, 32'h007F);
`endif
      chk("s1_emit_back_to_back", xlog[NCH-1].cyc == n0 + 78 + NCH - 1, xlog[NCH-1].cyc - n0, 78 + NCH - 1);
    end

    // scan 2: backpressure on ch1, stopped inverter ring, ignored extra single
    p0 = 0;
    meas_cnt_dff = 8'h01; meas_cnt_dice = 8'h80; meas_cnt_leap = 8'h00; skew_code = 7'h2A;
    repeat (5) tick();
    clear_logs();
    pulse_single(n0);
    repeat (3) tick();
    single = 1'b1;
    tick();
    single = 1'b0;
    wait_ch0_valid(200);
    tick();
    res_ready = 1'b0;
    d1 = int'(res_data);
    chk("bp_stall_ch", res_valid && res_ch == 3'd1, int'(res_ch), 1);
    repeat (10) tick();
    chk("bp_hold_valid", res_valid == 1'b1, int'(res_valid), 1);
    chk("bp_hold_ch", res_ch == 3'd1, int'(res_ch), 1);
    chk("bp_hold_data", int'(res_data) == d1, int'(res_data), d1);
    res_ready = 1'b1;
    wait_idle(300);
    chk("s2_xfer_count", xlog.size() == NCH, xlog.size(), NCH);
    chk("s2_ms_count", mslog.size() == 1, mslog.size(), 1);
    if (xlog.size() == NCH) begin
      for (int i = 0; i < NCH; i++) chk("s2_ch_order", xlog[i].ch == i, xlog[i].ch, i);
      chk("s2_ch0_stopped", xlog[0].data == 0, xlog[0].data, 0);
      chk("s2_ch2_dff", xlog[2].data == 32'h0001, xlog[2].data, 32'h0001);
      chk("s2_ch3_dice", xlog[3].data == 32'h0080, xlog[3].data, 32'h0080);
    end

    // continuous run, then drop run during the second scan's GATE
    p0 = 8;
    repeat (5) tick();
    clear_logs();
    run = 1'b1;
    wait_xfers(NCH, 300);
    repeat (20) tick();
    run = 1'b0;
    wait_idle(300);
    chk("run_xfer_count", xlog.size() == 2 * NCH, xlog.size(), 2 * NCH);
    chk("run_ms_count", mslog.size() == 2, mslog.size(), 2);
    if (mslog.size() == 2 && xlog.size() >= NCH)
      chk("run_no_gap", mslog[1] == xlog[NCH-1].cyc + 10 + G, mslog[1] - xlog[NCH-1].cyc, 10 + G);

    // reset asserted in SETTLE
    repeat (5) tick();
    clear_logs();
    pulse_single(n0);
    wait_ms(200);
    tick();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", busy == 1'b0, int'(busy), 0);
    chk("rstmid_valid", res_valid == 1'b0, int'(res_valid), 0);
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    chk("rstmid_no_valid", vrise.size() == 0, vrise.size(), 0);
    chk("rstmid_no_xfer", xlog.size() == 0, xlog.size(), 0);

    // saturating counter, narrow instance, max toggle rate
    sat_clr = 1'b1;
    tick(); tick();
    sat_clr = 1'b0;
    chk("sat_clear", sat_cnt == 4'd0, int'(sat_cnt), 0);
    repeat (10) begin sat_in = ~sat_in; tick(); end
    repeat (4) tick();
    chk("sat_disabled", sat_cnt == 4'd0, int'(sat_cnt), 0);
    sat_en = 1'b1;
    repeat (10) begin sat_in = ~sat_in; tick(); end
    repeat (4) tick();
    chk("sat_count5", sat_cnt == 4'd5, int'(sat_cnt), 5);
    repeat (60) begin sat_in = ~sat_in; tick(); end
    repeat (4) tick();
    chk("sat_full", sat_cnt == 4'hF, int'(sat_cnt), 15);
    repeat (10) begin sat_in = ~sat_in; tick(); end
    repeat (4) tick();
    chk("sat_no_wrap", sat_cnt == 4'hF, int'(sat_cnt), 15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
